// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with shift-and-add multiply; optional accumulate op 7 under SEQ_ALU_ACC_EN
module seq_alu #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               cin,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [0:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_sum;
    logic [2*WIDTH-1:0] alu_res;
    logic [2*WIDTH-1:0] acc_next;

    // busy is a pure decode of the registered state, so it is glitch-free
    assign busy = (state == S_MUL);

    assign add_sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
    assign sub_sum  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign acc_next = acc + (mplier[0] ? mcand : {2*WIDTH{1'b0}});

    // single-cycle result selection; the shift naturally yields 0 once B >= WIDTH
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD: alu_res[WIDTH:0]   = add_sum;
            OP_SUB: alu_res[WIDTH:0]   = sub_sum;
            OP_AND: alu_res[WIDTH-1:0] = A & B;
            OP_OR:  alu_res[WIDTH-1:0] = A | B;
            OP_XOR: alu_res[WIDTH-1:0] = A ^ B;
            OP_SHL: alu_res[WIDTH-1:0] = A << B;
`ifdef SEQ_ALU_ACC_EN
            3'd7:   alu_res = result + {{WIDTH{1'b0}}, A};
`else
            3'd7:   alu_res = '0;
`endif
            default: alu_res = '0;
        endcase
    end

    // start acceptance, multiply iteration and result/done registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            state  <= S_MUL;
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, A};
                            mplier <= B;
                            cnt    <= '0;
                        end else begin
                            result <= alu_res;
                            done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        result <= acc_next;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu with randomized ops against an arithmetic reference model
module tb_seq_alu;

    localparam int W      = 4;
    localparam int PERIOD = 10;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cin;
    logic [2*W-1:0] result;
    logic           busy;
    logic           done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2*W-1:0] res;
        time            t_acc;
        int             edges;
    } exp_t;

    exp_t q[$];
    logic [2*W-1:0] model_res;

    seq_alu #(.WIDTH(W), .CNT_W(5)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .start  (start),
        .op     (op),
        .A      (a),
        .B      (b),
        .cin    (cin),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: plain unsigned integer arithmetic on the spec's rules
    function automatic logic [2*W-1:0] model(input int o, input longint x, input longint y,
                                             input longint c, input longint prev);
        longint r;
        case (o)
            0: r = (x + y + c) % (longint'(1) << (W + 1));
            1: r = (x - y + (longint'(1) << W)) % (longint'(1) << (W + 1));
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = x * y;
            6: r = (y >= W) ? 0 : ((x * (longint'(1) << y)) % (longint'(1) << W));
`ifdef SEQ_ALU_ACC_EN
            7: r = (prev + x) % (longint'(1) << (2 * W));
`else
            7: r = 0;
`endif
            default: r = 0;
        endcase
        return r[2*W-1:0];
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("result", result, e.res);
                chk("done_latency", $time, e.t_acc + e.edges * PERIOD + PERIOD/2);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic do_op(input int o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input bit pulse);
        exp_t e;
        @(negedge clk);
        chk("busy_before_start", busy, 0);
        start = 1'b1;
        op    = o[2:0];
        a     = x;
        b     = y;
        cin   = c;
        @(posedge clk);
        e.res     = model(o, x, y, c, model_res);
        model_res = e.res;
        e.t_acc   = $time;
        e.edges   = (o == 5) ? W : 0;
        q.push_back(e);
        if (o == 5) begin
            #1;
            chk("busy_after_accept", busy, 1);
            @(negedge clk);
            // a start held through the multiply, including its final edge, must be ignored
            start = pulse;
            op    = 3'd0;
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            repeat (W) @(posedge clk);
            #1;
            chk("busy_after_mul", busy, 0);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        model_res = '0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // directed cases from the test plan
        do_op(0, 4'hF, 4'h1, 1'b0, 1'b0);
        do_op(1, 4'h3, 4'h5, 1'b0, 1'b0);
        do_op(1, 4'h5, 4'h3, 1'b0, 1'b0);
        do_op(5, 4'hF, 4'hF, 1'b0, 1'b1);
        idle(2);
        do_op(6, 4'h3, 4'h2, 1'b0, 1'b0);
        do_op(6, 4'h3, 4'h4, 1'b0, 1'b0);
        do_op(2, 4'hC, 4'hA, 1'b0, 1'b0);
        do_op(3, 4'hC, 4'hA, 1'b0, 1'b0);
        do_op(4, 4'hC, 4'hA, 1'b0, 1'b0);
        do_op(5, 4'hF, 4'h2, 1'b0, 1'b0);
        do_op(7, 4'h5, 4'h0, 1'b0, 1'b0);
        do_op(5, 4'hF, 4'hF, 1'b0, 1'b0);
        do_op(0, 4'hF, 4'hF, 1'b1, 1'b0);
        do_op(7, 4'h1, 4'h0, 1'b0, 1'b0);
        idle(1);

        // reset in the middle of a multiply aborts it without a done pulse
        @(negedge clk);
        start = 1'b1;
        op    = 3'd5;
        a     = 4'h7;
        b     = 4'h3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 4'h1, 4'h1, 1'b0, 1'b0);
        idle(W + 2);

        // randomized ops, mostly back-to-back, with occasional idle gaps
        for (int i = 0; i < 200; i++) begin
            do_op(int'($urandom_range(7, 0)), W'($urandom), W'($urandom), 1'($urandom),
                  1'($urandom));
            if ($urandom_range(7, 0) == 0) idle(int'($urandom_range(3, 1)));
        end

        idle(W + 3);
        chk("pending_expectations", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
